// File: rtl/lh_message_framer.sv
// lh_message_framer: byte-stream front-end for the light_hash core.
// Buffers framed input bytes in a small FIFO, sequences the core's
// HEAD / MESSAGE / TAIL command pulses one byte at a time, and returns the
// 64-bit digest plus the message byte count on a valid/ready output.
//
// Handshake semantics (input and digest sides alike): a transfer happens on
// the rising clk edge where valid and ready are both high. The producer holds
// its data stable while valid is high and ready is low. Valid never waits on
// ready. s_ready is low during reset and otherwise equals "FIFO not full".
// d_valid, once set, holds d_data/d_len stable until the d_ready handshake.
module lh_message_framer #(
    parameter int FIFO_DEPTH    = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       core_message_byte,
    output logic             core_message_valid,
    output logic [1:0]       core_state,
    input  logic             core_next_byte,
    input  logic [63:0]      core_digest,
    input  logic             core_digest_ready,
    output logic [63:0]      d_data,
    output logic [CNT_W-1:0] d_len,
    output logic             d_valid,
    input  logic             d_ready,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [AW:0]    FIFO_FULL  = (AW+1)'(FIFO_DEPTH);
    localparam logic [SW-1:0]  SETTLE_LD  = SW'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Core command encodings on core_state.
    localparam logic [1:0] CMD_HEAD = 2'b00;
    localparam logic [1:0] CMD_MSG  = 2'b10;
    localparam logic [1:0] CMD_TAIL = 2'b01;
    localparam logic [1:0] CMD_IDLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEAD   = 3'd1,
        ST_WAIT_H = 3'd2,
        ST_BYTE   = 3'd3,
        ST_WAIT_B = 3'd4,
        ST_TAIL   = 3'd5,
        ST_WAIT_D = 3'd6,
        ST_OUT    = 3'd7
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Input FIFO: entries are {last, data}.
    // ------------------------------------------------------------------
    logic [8:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_count;
    logic [AW:0]   count_nxt;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [8:0]    fifo_head;

    assign fifo_empty = (fifo_count == '0);
    assign push       = s_valid & s_ready;
    // The FSM consumes a byte only in BYTE and only when one is buffered.
    assign pop        = (state == ST_BYTE) & ~fifo_empty;
    assign fifo_head  = fifo_mem[rd_ptr];
    assign dbg_state  = state;

    // Next occupancy, used to register s_ready so it is exactly !full.
    always_comb begin
        count_nxt = fifo_count + (AW+1)'(push) - (AW+1)'(pop);
    end

    // FIFO storage; pointer reset is what flushes it, so no data reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {s_last, s_data};
        end
    end

    // FIFO pointers, occupancy and registered s_ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            s_ready    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_count <= count_nxt;
            s_ready    <= (count_nxt != FIFO_FULL);
        end
    end

    // ------------------------------------------------------------------
    // Command sequencer.
    // ------------------------------------------------------------------
    logic [SW-1:0]    settle_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic             last_seen;

    // Sequencer FSM with registered command and digest outputs. Every pulse
    // loads settle_cnt; the WAIT states count it down before looking at the
    // core's status lines, which lag the command by a few cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            core_message_valid <= 1'b0;
            core_state         <= CMD_IDLE;
            core_message_byte  <= 8'h00;
            d_valid            <= 1'b0;
            d_data             <= 64'h0;
            d_len              <= '0;
            busy               <= 1'b0;
            byte_cnt           <= '0;
            settle_cnt         <= '0;
            last_seen          <= 1'b0;
        end else begin
            core_message_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A buffered byte starts a message, but never while an
                    // earlier digest is still waiting for its consumer.
                    if (!fifo_empty && !d_valid) begin
                        state <= ST_HEAD;
                    end
                end
                ST_HEAD: begin
                    core_message_valid <= 1'b1;
                    core_state         <= CMD_HEAD;
                    byte_cnt           <= '0;
                    busy               <= 1'b1;
                    settle_cnt         <= SETTLE_LD;
                    state              <= ST_WAIT_H;
                end
                ST_WAIT_H: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end else if (!core_next_byte) begin
                        state <= ST_BYTE;
                    end
                end
                ST_BYTE: begin
                    // An empty FIFO mid-message just parks here without pulses.
                    if (!fifo_empty) begin
                        core_message_valid <= 1'b1;
                        core_state         <= CMD_MSG;
                        core_message_byte  <= fifo_head[7:0];
                        last_seen          <= fifo_head[8];
                        if (byte_cnt != CNT_MAX) begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                        settle_cnt <= SETTLE_LD;
                        state      <= ST_WAIT_B;
                    end
                end
                ST_WAIT_B: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end else if (!core_next_byte) begin
                        state <= last_seen ? ST_TAIL : ST_BYTE;
                    end
                end
                ST_TAIL: begin
                    core_message_valid <= 1'b1;
                    core_state         <= CMD_TAIL;
                    settle_cnt         <= SETTLE_LD;
                    state              <= ST_WAIT_D;
                end
                ST_WAIT_D: begin
                    if (settle_cnt != '0) begin
                        settle_cnt <= settle_cnt - SW'(1);
                    end else if (core_digest_ready) begin
                        d_data  <= core_digest;
                        d_len   <= byte_cnt;
                        d_valid <= 1'b1;
                        state   <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (d_ready) begin
                        d_valid <= 1'b0;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lh_message_framer.sv
// Directed bench for lh_message_framer. A behavioural stand-in for the
// light_hash core hashes each MESSAGE byte with 64-bit FNV-1a, can hold
// next_byte high for a programmable number of cycles after every pulse, and
// can stall indefinitely after the first MESSAGE pulse.
module tb_lh_message_framer;

    localparam int SETTLE = 2;
    localparam logic [63:0] FNV_OFF   = 64'hcbf29ce484222325;
    localparam logic [63:0] FNV_PRIME = 64'h00000100000001b3;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  core_message_byte;
    logic        core_message_valid;
    logic [1:0]  core_state;
    logic        core_next_byte;
    logic [63:0] core_digest;
    logic        core_digest_ready;
    logic [63:0] d_data;
    logic [15:0] d_len;
    logic        d_valid;
    logic        d_ready;
    logic        busy;
    logic [2:0]  dbg_state;

    lh_message_framer #(.FIFO_DEPTH(8), .SETTLE_CYCLES(SETTLE), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .core_message_byte(core_message_byte), .core_message_valid(core_message_valid),
        .core_state(core_state), .core_next_byte(core_next_byte),
        .core_digest(core_digest), .core_digest_ready(core_digest_ready),
        .d_data(d_data), .d_len(d_len), .d_valid(d_valid), .d_ready(d_ready),
        .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- counters ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- core stand-in ----------------
    int          stub_busy = 0;
    logic        hold      = 1'b0;
    int          busy_cnt  = 0;
    int          dig_cnt   = 0;
    logic        seen_msg  = 1'b0;
    logic        dig_rdy   = 1'b0;
    logic [63:0] acc       = FNV_OFF;

    always @(posedge clk) begin
        if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
        if (dig_cnt != 0) begin
            dig_cnt <= dig_cnt - 1;
            if (dig_cnt == 1) dig_rdy <= 1'b1;
        end
        if (core_message_valid) begin
            busy_cnt <= stub_busy;
            case (core_state)
                2'b00: begin acc <= FNV_OFF; dig_rdy <= 1'b0; seen_msg <= 1'b0; end
                2'b10: begin acc <= (acc ^ {56'd0, core_message_byte}) * FNV_PRIME; seen_msg <= 1'b1; end
                2'b01: dig_cnt <= stub_busy + 3;
                default: ;
            endcase
        end
    end

    assign core_next_byte    = (busy_cnt != 0) || (hold && seen_msg);
    assign core_digest       = dig_rdy ? acc : ~acc;
    assign core_digest_ready = dig_rdy;

    function automatic logic [63:0] fnv(input string s);
        logic [63:0] h = FNV_OFF;
        for (int i = 0; i < s.len(); i++) h = (h ^ {56'd0, s[i]}) * FNV_PRIME;
        return h;
    endfunction

    // ---------------- scoreboard: expected command pulses {state, byte} ----------------
    logic [9:0] exp_q[$];
    logic       sb_en      = 1'b1;
    logic       prev_valid = 1'b0;
    logic       have_last  = 1'b0;
    int         cyc        = 0;
    int         last_cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && core_message_valid) begin
            check("double_pulse", prev_valid, 0);
            if (have_last) check("pulse_spacing", ((cyc - last_cyc) >= (1 + SETTLE + stub_busy)), 1);
            last_cyc  = cyc;
            have_last = 1'b1;
            if (core_state == 2'b00) check("head_while_dvalid", d_valid, 0);
            if (sb_en) begin
                check("pulse_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("core_state", core_state, e[9:8]);
                    if (e[9:8] == 2'b10) check("core_message_byte", core_message_byte, e[7:0]);
                end
            end
        end
        prev_valid = rst_n && core_message_valid;
    end

    task automatic expect_msg(input string s);
        exp_q.push_back({2'b00, 8'h00});
        for (int i = 0; i < s.len(); i++) exp_q.push_back({2'b10, s[i]});
        exp_q.push_back({2'b01, 8'h00});
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic push_byte(input logic [7:0] b, input logic l);
        int n = 0;
        s_data = b; s_last = l; s_valid = 1'b1;
        while (!s_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) check("push_timeout", s_ready, 1);
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_msg(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) begin
            push_byte(s[i], (i == s.len() - 1));
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_dvalid(input int budget);
        int n = 0;
        while (!d_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("dvalid_timeout", d_valid, 1);
    endtask

    task automatic take_digest(input string s, input int len);
        wait_dvalid(4000);
        check({"d_data ", s}, d_data, fnv(s));
        check({"d_len ", s}, d_len, len);
        d_ready = 1'b1;
        @(negedge clk);
        check("d_valid_cleared", d_valid, 0);
        check("busy_cleared", busy, 0);
        d_ready = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_s_ready", s_ready, 0);
        check("rst_core_valid", core_message_valid, 0);
        check("rst_core_state", core_state, 2'b11);
        check("rst_core_byte", core_message_byte, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_d_data", d_data, 0);
        check("rst_d_len", d_len, 0);
        check("rst_busy", busy, 0);
        check("rst_fsm_idle", dbg_state, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        logic rdy;
        string fifo_msg;
        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; d_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_after_reset", s_ready, 1);

        // Basic message
        expect_msg("H4rdw4r3_Tr0j4n");
        send_msg("H4rdw4r3_Tr0j4n", 0);
        take_digest("H4rdw4r3_Tr0j4n", 15);
        check("basic_pulses_done", exp_q.size(), 0);

        // Back-to-back messages with digest back-pressure
        expect_msg("AlessandroAndGiacomo");
        expect_msg("AlessandroandGiacomo");
        fork
            begin
                send_msg("AlessandroAndGiacomo", 0);
                send_msg("AlessandroandGiacomo", 0);
            end
            begin
                wait_dvalid(4000);
                check("b2b_d_data1", d_data, fnv("AlessandroAndGiacomo"));
                check("b2b_d_len1", d_len, 20);
                repeat (10) @(negedge clk);
                check("b2b_hold_valid", d_valid, 1);
                check("b2b_hold_data", d_data, fnv("AlessandroAndGiacomo"));
                check("b2b_fifo_full", s_ready, 0);
                check("b2b_busy", busy, 1);
                check("b2b_fsm_out", dbg_state, 3'd7);
                d_ready = 1'b1;
                @(negedge clk);
                check("b2b_handshake", d_valid, 0);
                d_ready = 1'b0;
            end
        join
        take_digest("AlessandroandGiacomo", 20);
        check("b2b_pulses_done", exp_q.size(), 0);

        // Slow source: framer must idle in BYTE between bytes
        expect_msg("3.141592653589793238");
        fork
            send_msg("3.141592653589793238", 37);
            begin
                repeat (135) @(negedge clk);
                check("slow_no_pulse", core_message_valid, 0);
                check("slow_fsm_byte", dbg_state, 3'd3);
            end
        join
        take_digest("3.141592653589793238", 20);

        // Pulse protocol against a core that stays busy 5 cycles per command
        stub_busy = 5;
        expect_msg("Tr0j");
        send_msg("Tr0j", 0);
        take_digest("Tr0j", 4);
        check("proto_pulses_done", exp_q.size(), 0);
        stub_busy = 0;

        // FIFO boundary: core stalls after the first MESSAGE pulse
        fifo_msg = "ABCDEFGHIJKL";
        hold = 1'b1;
        expect_msg(fifo_msg);
        k = 0;
        for (int c = 0; c < 60 && k < 12; c++) begin
            s_data = fifo_msg[k]; s_last = (k == 11); s_valid = 1'b1;
            rdy = s_ready;
            @(negedge clk);
            if (rdy) k++;
        end
        check("fifo_accepted", k, 9);
        check("fifo_full_ready", s_ready, 0);
        hold = 1'b0;
        for (int c = 0; c < 400 && k < 12; c++) begin
            s_data = fifo_msg[k]; s_last = (k == 11); s_valid = 1'b1;
            rdy = s_ready;
            @(negedge clk);
            if (rdy) begin
                k++;
                if (k == 10) check("fifo_refill_full", s_ready, 0);
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        check("fifo_all_sent", k, 12);
        take_digest(fifo_msg, 12);

        // Reset in the middle of a message
        sb_en = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'(i + 8'h41), 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        exp_q.delete();
        sb_en = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_idle", dbg_state, 0);
        check("post_reset_ready", s_ready, 1);
        check("post_reset_busy", busy, 0);
        expect_msg("H4rdw4r3_Tr0j4n");
        send_msg("H4rdw4r3_Tr0j4n", 0);
        take_digest("H4rdw4r3_Tr0j4n", 15);
        check("final_pulses_done", exp_q.size(), 0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
